// File: rtl/apb_uart_csr.sv
// APB3 control/status register block for the UART: configuration, TX push, RX pop,
// status and a sticky maskable interrupt, with byte strobes, wait states and error responses.
module apb_uart_csr #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK_i,
    input  logic                    PRESETn_i,
    input  logic [ADDR_WIDTH-1:0]   PADDR_i,
    input  logic                    PWRITE_i,
    input  logic                    PSEL_i,
    input  logic                    PENABLE_i,
    input  logic [DATA_WIDTH-1:0]   PWDATA_i,
    input  logic [DATA_WIDTH/8-1:0] PSTRB_i,
    output logic [DATA_WIDTH-1:0]   PRDATA_o,
    output logic                    PREADY_o,
    output logic                    PSLVERR_o,
    output logic [1:0]              baud_rate_o,
    output logic [1:0]              parity_type_o,
    output logic                    wr_uart_o,
    output logic [7:0]              wr_data_o,
    output logic                    rd_uart_o,
    input  logic [7:0]              rd_data_i,
    input  logic                    tx_fifo_full_i,
    input  logic                    tx_fifo_empty_i,
    input  logic                    rx_fifo_full_i,
    input  logic                    rx_fifo_empty_i,
    input  logic [2:0]              error_flag_i,
    output logic                    irq_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [2:0] IDX_TXDATA   = 3'd0;
    localparam logic [2:0] IDX_RXDATA   = 3'd1;
    localparam logic [2:0] IDX_CTRL     = 3'd2;
    localparam logic [2:0] IDX_STATUS   = 3'd3;
    localparam logic [2:0] IDX_INT_EN   = 3'd4;
    localparam logic [2:0] IDX_INT_STAT = 3'd5;
    localparam logic [1:0] WAIT_LOAD    = 2'(WAIT_STATES);

    state_t     state_q, state_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] baud_q, baud_d;
    logic [1:0] parity_q, parity_d;
    logic [4:0] int_en_q, int_en_d;
    logic [2:0] sticky_q, sticky_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_uart_q, wr_uart_d;
    logic       rd_uart_q, rd_uart_d;
    logic       irq_q, irq_d;

    logic [2:0] reg_idx;
    logic       addr_hi_zero;
    logic       xfer_done;
    logic       access_err;
    logic [7:0] rd_byte;
    logic [4:0] int_stat;
    logic [2:0] sticky_clr;
    logic       wr_commit;
    logic       rd_commit;
    logic       unused_bits;

    assign reg_idx = PADDR_i[4:2];

    // Any address bit above the 32-byte window makes the access unmapped.
    generate
        if (ADDR_WIDTH > 5) begin : g_addr_hi
            assign addr_hi_zero = (PADDR_i[ADDR_WIDTH-1:5] == '0);
        end else begin : g_addr_exact
            assign addr_hi_zero = 1'b1;
        end
    endgenerate

    assign unused_bits = ^{PWDATA_i, PSTRB_i};

    assign int_stat  = {sticky_q, tx_fifo_empty_i, ~rx_fifo_empty_i};
    assign xfer_done = (state_q == ST_ACCESS) && (wait_cnt_q == 2'd0) && PSEL_i && PENABLE_i;
    assign wr_commit = xfer_done && PWRITE_i && !access_err && PSTRB_i[0];
    assign rd_commit = xfer_done && !PWRITE_i && !access_err;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL_i && !PENABLE_i) begin
                    state_d    = ST_ACCESS;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            ST_ACCESS: begin
                if (!PSEL_i) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q != 2'd0) begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end else if (PENABLE_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A TXDATA write without lane 0 is an error, unlike the other writable registers.
    always_comb begin
        access_err = 1'b0;
        rd_byte    = 8'h00;
        if (!addr_hi_zero || (PADDR_i[1:0] != 2'b00)) begin
            access_err = 1'b1;
        end else begin
            case (reg_idx)
                IDX_TXDATA: begin
                    if (!PWRITE_i || tx_fifo_full_i || !PSTRB_i[0]) access_err = 1'b1;
                end
                IDX_RXDATA: begin
                    if (PWRITE_i || rx_fifo_empty_i) access_err = 1'b1;
                    else                             rd_byte    = rd_data_i;
                end
                IDX_CTRL:     rd_byte = {4'b0000, parity_q, baud_q};
                IDX_STATUS: begin
                    if (PWRITE_i) access_err = 1'b1;
                    else rd_byte = {4'b0000, tx_fifo_full_i, tx_fifo_empty_i,
                                    rx_fifo_full_i, rx_fifo_empty_i};
                end
                IDX_INT_EN:   rd_byte = {3'b000, int_en_q};
                IDX_INT_STAT: rd_byte = {3'b000, int_stat};
                default:      access_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        PRDATA_o = '0;
        if (rd_commit) PRDATA_o[7:0] = rd_byte;
    end

    assign PREADY_o  = xfer_done;
    assign PSLVERR_o = xfer_done && access_err;

    always_comb begin
        baud_d     = baud_q;
        parity_d   = parity_q;
        int_en_d   = int_en_q;
        wr_data_d  = wr_data_q;
        wr_uart_d  = 1'b0;
        rd_uart_d  = 1'b0;
        sticky_clr = 3'b000;
        if (wr_commit) begin
            case (reg_idx)
                IDX_TXDATA: begin
                    wr_uart_d = 1'b1;
                    wr_data_d = PWDATA_i[7:0];
                end
                IDX_CTRL: begin
                    baud_d   = PWDATA_i[1:0];
                    parity_d = PWDATA_i[3:2];
                end
                IDX_INT_EN:   int_en_d   = PWDATA_i[4:0];
                IDX_INT_STAT: sticky_clr = PWDATA_i[4:2];
                default: ;
            endcase
        end
        if (rd_commit && (reg_idx == IDX_RXDATA)) rd_uart_d = 1'b1;
        // OR-ing the new error after the clear lets a simultaneous set win.
        sticky_d = (sticky_q & ~sticky_clr) | error_flag_i;
        irq_d    = |(int_stat & int_en_q);
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 2'd0;
            baud_q     <= 2'b00;
            parity_q   <= 2'b00;
            int_en_q   <= 5'b00000;
            sticky_q   <= 3'b000;
            wr_data_q  <= 8'h00;
            wr_uart_q  <= 1'b0;
            rd_uart_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            baud_q     <= baud_d;
            parity_q   <= parity_d;
            int_en_q   <= int_en_d;
            sticky_q   <= sticky_d;
            wr_data_q  <= wr_data_d;
            wr_uart_q  <= wr_uart_d;
            rd_uart_q  <= rd_uart_d;
            irq_q      <= irq_d;
        end
    end

    assign baud_rate_o   = baud_q;
    assign parity_type_o = parity_q;
    assign wr_uart_o     = wr_uart_q;
    assign wr_data_o     = wr_data_q;
    assign rd_uart_o     = rd_uart_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_apb_uart_csr.sv
// Directed and randomized bench for apb_uart_csr against a register-level reference model.
module tb_apb_uart_csr;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        PRESETn;
    logic [4:0]  PADDR;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [7:0]  rd_data;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [2:0]  error_flag;

    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [1:0]  baud, parity;
    logic        wr_uart, rd_uart, irq;
    logic [7:0]  wr_data;

    logic [31:0] d0_prdata;
    logic        d0_pready, d0_pslverr;
    logic [1:0]  d0_unused_baud, d0_unused_parity;
    logic        d0_unused_wr_uart, d0_unused_rd_uart, d0_unused_irq;
    logic [7:0]  d0_unused_wr_data;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    logic [1:0]  m_baud, m_parity;
    logic [4:0]  m_int_en;
    logic [2:0]  m_sticky;
    logic [7:0]  m_wr_data;
    int          m_wr_cnt, m_rd_cnt;

    always #5 clk = ~clk;

    apb_uart_csr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WAIT_STATES(WS)) u_dut (
        .PCLK_i(clk), .PRESETn_i(PRESETn), .PADDR_i(PADDR), .PWRITE_i(PWRITE),
        .PSEL_i(PSEL), .PENABLE_i(PENABLE), .PWDATA_i(PWDATA), .PSTRB_i(PSTRB),
        .PRDATA_o(PRDATA), .PREADY_o(PREADY), .PSLVERR_o(PSLVERR),
        .baud_rate_o(baud), .parity_type_o(parity), .wr_uart_o(wr_uart),
        .wr_data_o(wr_data), .rd_uart_o(rd_uart), .rd_data_i(rd_data),
        .tx_fifo_full_i(tx_full), .tx_fifo_empty_i(tx_empty),
        .rx_fifo_full_i(rx_full), .rx_fifo_empty_i(rx_empty),
        .error_flag_i(error_flag), .irq_o(irq)
    );

    // Zero-wait-state instance on the same bus: completes on the first access cycle.
    apb_uart_csr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WAIT_STATES(0)) u_dut0 (
        .PCLK_i(clk), .PRESETn_i(PRESETn), .PADDR_i(PADDR), .PWRITE_i(PWRITE),
        .PSEL_i(PSEL), .PENABLE_i(PENABLE), .PWDATA_i(PWDATA), .PSTRB_i(PSTRB),
        .PRDATA_o(d0_prdata), .PREADY_o(d0_pready), .PSLVERR_o(d0_pslverr),
        .baud_rate_o(d0_unused_baud), .parity_type_o(d0_unused_parity),
        .wr_uart_o(d0_unused_wr_uart), .wr_data_o(d0_unused_wr_data),
        .rd_uart_o(d0_unused_rd_uart), .rd_data_i(rd_data),
        .tx_fifo_full_i(tx_full), .tx_fifo_empty_i(tx_empty),
        .rx_fifo_full_i(rx_full), .rx_fifo_empty_i(rx_empty),
        .error_flag_i(error_flag), .irq_o(d0_unused_irq)
    );

    always @(negedge clk) begin
        if (wr_uart === 1'b1) wr_cnt <= wr_cnt + 1;
        if (rd_uart === 1'b1) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic wr, input logic [4:0] a, input logic s0);
        if (a[1:0] != 2'b00) return 1'b1;
        case (a)
            5'h00:               return !wr || tx_full || !s0;
            5'h04:               return wr || rx_empty;
            5'h0C:               return wr;
            5'h08, 5'h10, 5'h14: return 1'b0;
            default:             return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a, input logic [2:0] e);
        case (a)
            5'h04:   return {24'h0, rd_data};
            5'h08:   return {28'h0, m_parity, m_baud};
            5'h0C:   return {28'h0, tx_full, tx_empty, rx_full, rx_empty};
            5'h10:   return {27'h0, m_int_en};
            5'h14:   return {27'h0, m_sticky | e, tx_empty, !rx_empty};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq(input logic [2:0] s, input logic [4:0] en);
        return |({s, tx_empty, !rx_empty} & en);
    endfunction

    task automatic model_reset();
        m_baud = 2'b00; m_parity = 2'b00; m_int_en = 5'h0; m_sticky = 3'b000; m_wr_data = 8'h00;
    endtask

    // Bus-level transfer; returns at 1ns after the completing edge.
    task automatic xfer(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] e,
                        output logic [31:0] rdat, output logic serr, output int n,
                        output logic d0r, output logic d0e, output logic [31:0] d0d);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = st;
        @(posedge clk); #1;
        PENABLE = 1'b1; error_flag = e;
        n = 1;
        @(negedge clk);
        d0r = d0_pready; d0e = d0_pslverr; d0d = d0_prdata;
        while (PREADY !== 1'b1 && n < 8) begin
            chk("wait_prdata", PRDATA, 32'h0);
            chk("wait_slverr", PSLVERR, 1'b0);
            @(posedge clk); #1;
            n++;
            @(negedge clk);
        end
        rdat = PRDATA; serr = PSLVERR;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; error_flag = 3'b000;
    endtask

    task automatic do_xfer(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] e);
        logic [31:0] rdat, d0d, exp_rd;
        logic serr, d0r, d0e, exp_err, exp_push, exp_pop, irq_prev;
        int n;
        exp_err  = model_err(wr, a, st[0]);
        exp_rd   = (wr || exp_err) ? 32'h0 : model_rd(a, e);
        exp_push = wr && !exp_err && (a == 5'h00);
        exp_pop  = !wr && !exp_err && (a == 5'h04);
        irq_prev = model_irq(m_sticky | e, m_int_en);
        xfer(wr, a, wd, st, e, rdat, serr, n, d0r, d0e, d0d);
        chk("xfer_len", n, WS + 1);
        chk("pslverr", serr, exp_err);
        chk("prdata", rdat, exp_rd);
        chk("ws0_pready", d0r, 1'b1);
        chk("ws0_pslverr", d0e, exp_err);
        if (a != 5'h14) chk("ws0_prdata", d0d, exp_rd);
        m_sticky = m_sticky | e;
        if (wr && !exp_err && st[0]) begin
            case (a)
                5'h00: begin m_wr_cnt++; m_wr_data = wd[7:0]; end
                5'h08: begin m_baud = wd[1:0]; m_parity = wd[3:2]; end
                5'h10: m_int_en = wd[4:0];
                5'h14: m_sticky = (m_sticky & ~wd[4:2]) | e;
                default: ;
            endcase
        end
        if (exp_pop) m_rd_cnt++;
        @(negedge clk);
        chk("wr_uart_pulse", wr_uart, exp_push);
        chk("rd_uart_pulse", rd_uart, exp_pop);
        chk("wr_data", wr_data, m_wr_data);
        chk("ctrl_out", {parity, baud}, {m_parity, m_baud});
        chk("irq_hold", irq, irq_prev);
        @(negedge clk);
        chk("pulse_end", {wr_uart, rd_uart}, 2'b00);
        chk("irq", irq, model_irq(m_sticky, m_int_en));
        chk("wr_count", wr_cnt, m_wr_cnt);
        chk("rd_count", rd_cnt, m_rd_cnt);
        $display("xfer %s addr=0x%02h wdata=0x%08h strb=%b eflag=%b -> prdata=0x%08h slverr=%0b",
                 wr ? "WR" : "RD", a, wd, st, e, rdat, serr);
    endtask

    task automatic pulse_err(input logic [2:0] e);
        @(posedge clk); #1; error_flag = e;
        @(posedge clk); #1; error_flag = 3'b000;
        m_sticky = m_sticky | e;
        @(negedge clk);
        @(negedge clk);
        chk("irq_after_err", irq, model_irq(m_sticky, m_int_en));
        $display("error pulse eflag=%b irq=%0b", e, irq);
    endtask

    initial begin
        logic [4:0] addr_tab [9];
        addr_tab = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C, 5'h09};
        PRESETn = 1'b0; PADDR = 5'h0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        PWDATA = 32'h0; PSTRB = 4'h0; rd_data = 8'h0; error_flag = 3'b000;
        tx_full = 1'b0; tx_empty = 1'b1; rx_full = 1'b0; rx_empty = 1'b1;
        m_wr_cnt = 0; m_rd_cnt = 0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        chk("rst_ctrl", {parity, baud}, 4'h0);
        chk("rst_pulses", {wr_uart, rd_uart}, 2'b00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_irq", irq, 1'b0);
        $display("reset check done");
        @(posedge clk); #1; PRESETn = 1'b1;

        do_xfer(1'b0, 5'h08, 32'h0, 4'h0, 3'b000);
        do_xfer(1'b0, 5'h10, 32'h0, 4'h0, 3'b000);
        do_xfer(1'b0, 5'h0C, 32'h0, 4'h0, 3'b000);

        do_xfer(1'b1, 5'h00, 32'h0000_00A5, 4'b0001, 3'b000);
        tx_full = 1'b1; tx_empty = 1'b0;
        do_xfer(1'b1, 5'h00, 32'h0000_005A, 4'b0001, 3'b000);
        tx_full = 1'b0; tx_empty = 1'b1;
        do_xfer(1'b1, 5'h00, 32'h0000_0011, 4'b1110, 3'b000);

        rd_data = 8'h3C; rx_empty = 1'b0;
        do_xfer(1'b0, 5'h04, 32'h0, 4'h0, 3'b000);
        rx_empty = 1'b1;
        do_xfer(1'b0, 5'h04, 32'h0, 4'h0, 3'b000);

        do_xfer(1'b1, 5'h10, 32'h0000_0008, 4'b0001, 3'b000);
        pulse_err(3'b010);
        do_xfer(1'b0, 5'h14, 32'h0, 4'h0, 3'b000);
        do_xfer(1'b1, 5'h14, 32'h0000_0008, 4'b0001, 3'b010);
        do_xfer(1'b1, 5'h14, 32'h0000_0008, 4'b0001, 3'b000);

        do_xfer(1'b1, 5'h08, 32'h0000_000B, 4'b0001, 3'b000);
        do_xfer(1'b0, 5'h18, 32'h0, 4'h0, 3'b000);
        do_xfer(1'b0, 5'h02, 32'h0, 4'h0, 3'b000);
        do_xfer(1'b1, 5'h0C, 32'h0000_000F, 4'b1111, 3'b000);
        do_xfer(1'b1, 5'h08, 32'h0000_000F, 4'b0000, 3'b000);
        do_xfer(1'b0, 5'h08, 32'h0, 4'h0, 3'b000);

        // Aborted TXDATA write: PSEL drops before the transfer can complete.
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h00; PWDATA = 32'h66; PSTRB = 4'h1;
        @(posedge clk); #1; PENABLE = 1'b1;
        @(posedge clk); #1; PSEL = 1'b0; PENABLE = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_push", wr_cnt, m_wr_cnt);
        $display("abort transfer wr_cnt=%0d", wr_cnt);

        for (int i = 0; i < 50; i++) begin
            logic [4:0] a;
            logic [2:0] e;
            a        = addr_tab[$urandom_range(0, 8)];
            tx_full  = 1'($urandom);
            tx_empty = 1'($urandom);
            rx_full  = 1'($urandom);
            rx_empty = 1'($urandom);
            rd_data  = 8'($urandom);
            e        = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            do_xfer(1'($urandom), a, $urandom, 4'($urandom), e);
        end

        tx_full = 1'b0; tx_empty = 1'b1; rx_full = 1'b0; rx_empty = 1'b1;
        do_xfer(1'b1, 5'h10, 32'h0000_0002, 4'b0001, 3'b000);
        do_xfer(1'b1, 5'h08, 32'h0000_0006, 4'b0001, 3'b000);
        do_xfer(1'b1, 5'h00, 32'h0000_00C3, 4'b0001, 3'b000);

        // Reset asserted in the cycle that would otherwise complete a TXDATA write.
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h00; PWDATA = 32'h77; PSTRB = 4'h1;
        @(posedge clk); #1; PENABLE = 1'b1;
        repeat (WS) begin @(posedge clk); #1; end
        PRESETn = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_pready", PREADY, 1'b0);
        chk("midrst_prdata", PRDATA, 32'h0);
        chk("midrst_pslverr", PSLVERR, 1'b0);
        chk("midrst_ctrl", {parity, baud}, 4'h0);
        chk("midrst_wr_data", wr_data, 8'h00);
        chk("midrst_irq", irq, 1'b0);
        @(posedge clk); #1; PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge clk); #1; PRESETn = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_push", wr_cnt, m_wr_cnt);
        $display("mid-transfer reset wr_cnt=%0d", wr_cnt);
        do_xfer(1'b0, 5'h08, 32'h0, 4'h0, 3'b000);
        do_xfer(1'b0, 5'h10, 32'h0, 4'h0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
